alu_issue_ctrl: RTL

//  Multi-cycle controller on the driving side of the 3-bit-ALUOp 32-bit ALU.
//  - Accepts MIPS instruction words over a valid/ready handshake.
//  - Decodes each word into ALUOp plus operands A/B, taken from an internal 32x32 GPR file.
//  - Drives the external combinational ALU, captures C and writes the result back to the GPR.

---
 rtl/alu_issue_ctrl_pkg.sv | 41 ++++
 rtl/alu_issue_gpr.sv | 44 ++++
 rtl/alu_issue_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// ============================================================================
// alu_issue_ctrl_pkg : ALU op codes, MIPS opcode/funct constants, FSM states
// Rev 1.0
// ============================================================================
`default_nettype none

package alu_issue_ctrl_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SRL = 3'b100,
        ALU_SRA = 3'b101
    } alu_op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DEC  = 3'd1,
        S_EXE  = 3'd2,
        S_WB   = 3'd3,
        S_DONE = 3'd4
    } state_e;

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_addiu = 6'b001001;
    localparam logic [5:0] c_op_andi  = 6'b001100;
    localparam logic [5:0] c_op_ori   = 6'b001101;
    localparam logic [5:0] c_op_lui   = 6'b001111;

    localparam logic [5:0] c_fn_addu  = 6'b100001;
    localparam logic [5:0] c_fn_subu  = 6'b100011;
    localparam logic [5:0] c_fn_and   = 6'b100100;
    localparam logic [5:0] c_fn_or    = 6'b100101;
    localparam logic [5:0] c_fn_srlv  = 6'b000110;
    localparam logic [5:0] c_fn_srav  = 6'b000111;

endpackage

`default_nettype wire

// File: rtl/alu_issue_gpr.sv
// ============================================================================
// alu_issue_gpr : register file, three combinational reads, one write port
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_issue_gpr #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [ADDR_W-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o,
    input  logic [ADDR_W-1:0] raddr_d_i,
    output logic [DATA_W-1:0] rdata_d_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Register 0 is hard-wired to zero on every read port
    assign rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];
    assign rdata_d_o = (raddr_d_i == '0) ? '0 : regs_q[raddr_d_i];

endmodule

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// ============================================================================
// alu_issue_ctrl : 4-cycle MIPS issue/decode/writeback FSM driving an external ALU
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    output logic              instr_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_c,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_reg,
    output logic [DATA_W-1:0] wb_data,
    output logic              illegal,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_e            state_q, state_d;
    logic [31:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    alu_op_e           op_q, op_d;
    logic [ADDR_W-1:0] dest_q, dest_d;

    logic [5:0]        opcode, funct;
    logic [ADDR_W-1:0] rs_idx, rt_idx, rd_idx;
    logic [15:0]       imm;
    logic [DATA_W-1:0] rs_data, rt_data;

    logic              dec_legal;
    logic [DATA_W-1:0] dec_a, dec_b;
    alu_op_e           dec_op;
    logic [ADDR_W-1:0] dec_dest;

    assign opcode = ir_q[31:26];
    assign rs_idx = ir_q[25:21];
    assign rt_idx = ir_q[20:16];
    assign rd_idx = ir_q[15:11];
    assign funct  = ir_q[5:0];
    assign imm    = ir_q[15:0];

    alu_issue_gpr #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_gpr (
        .clk_i     (clk),
        .reset_i   (reset),
        .we_i      (state_q == S_WB),
        .waddr_i   (dest_q),
        .wdata_i   (res_q),
        .raddr_a_i (rs_idx),
        .rdata_a_o (rs_data),
        .raddr_b_i (rt_idx),
        .rdata_b_o (rt_data),
        .raddr_d_i (dbg_addr),
        .rdata_d_o (dbg_data)
    );

    always_comb begin
        dec_legal = 1'b1;
        dec_a     = rs_data;
        dec_b     = rt_data;
        dec_op    = ALU_ADD;
        dec_dest  = rd_idx;
        case (opcode)
            c_op_rtype: begin
                case (funct)
                    c_fn_addu: dec_op = ALU_ADD;
                    c_fn_subu: dec_op = ALU_SUB;
                    c_fn_and:  dec_op = ALU_AND;
                    c_fn_or:   dec_op = ALU_OR;
                    // Variable shifts: value comes from rt, amount from rs[4:0]
                    c_fn_srlv: begin
                        dec_op = ALU_SRL;
                        dec_a  = rt_data;
                        dec_b  = {{(DATA_W-5){1'b0}}, rs_data[4:0]};
                    end
                    c_fn_srav: begin
                        dec_op = ALU_SRA;
                        dec_a  = rt_data;
                        dec_b  = {{(DATA_W-5){1'b0}}, rs_data[4:0]};
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            c_op_addiu: begin
                dec_dest = rt_idx;
                dec_b    = {{(DATA_W-16){imm[15]}}, imm};
            end
            c_op_andi: begin
                dec_dest = rt_idx;
                dec_op   = ALU_AND;
                dec_b    = {{(DATA_W-16){1'b0}}, imm};
            end
            c_op_ori: begin
                dec_dest = rt_idx;
                dec_op   = ALU_OR;
                dec_b    = {{(DATA_W-16){1'b0}}, imm};
            end
            c_op_lui: begin
                dec_dest = rt_idx;
                dec_op   = ALU_OR;
                dec_a    = {imm, {(DATA_W-16){1'b0}}};
                dec_b    = '0;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        dest_d  = dest_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = S_DEC;
                end
            end
            S_DEC: begin
                if (dec_legal) begin
                    a_d     = dec_a;
                    b_d     = dec_b;
                    op_d    = dec_op;
                    dest_d  = dec_dest;
                    state_d = S_EXE;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_EXE: begin
                res_d   = alu_c;
                state_d = S_WB;
            end
            S_WB:    state_d = S_IDLE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= ALU_ADD;
            dest_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            dest_q  <= dest_d;
            res_q   <= res_d;
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign wb_valid    = (state_q == S_WB);
    assign illegal     = (state_q == S_DONE);
    assign wb_reg      = dest_q;
    assign wb_data     = res_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_op      = op_q;

endmodule

`default_nettype wire
